hms_time_counter: RTL and testbench
===================================

# hms_time_counter

Hours/minutes/seconds timekeeping counter for the clock datapath. Registers three time fields and advances them on a one-cycle `tick` enable, with each field's "+1" computed by a `ripplenbit_add` incrementer. It sits directly upstream of the adder: it supplies the adder's operands and registers its sums. A valid/ready load port presets the time, and a run/stop FSM gates counting.

## Interface
- `N_SEC`, default 60: seconds modulus; legal values 0..59.
- `N_MIN`, default 60: minutes modulus; legal values 0..59.
- `N_HOUR`, default 24: hours modulus; legal values 0..23.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle count enable, nominally 1 Hz.
- `run`  in  1  level input: 1 = count ticks, 0 = hold.
- `load_valid`  in  1  preset request.
- `load_ready`  out  1  preset can be accepted this cycle.
- `load_sec`  in  6  preset seconds.
- `load_min`  in  6  preset minutes.
- `load_hour`  in  5  preset hours.
- `load_err`  out  1  one-cycle pulse: a preset was rejected as out of range.
- `sec`  out  6  current seconds.
- `min`  out  6  current minutes.
- `hour`  out  5  current hours.
- `min_pulse`  out  1  one-cycle pulse on a seconds wrap.
- `day_pulse`  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 wrap.

## Operation
- Reset values: `sec`, `min`, `hour` = 0; `load_ready` = 1; `load_err`, `min_pulse`, `day_pulse` = 0; FSM state = STOP.
- FSM states: STOP, RUN, ACK.
  - STOP -> RUN when `run`=1.
  - RUN -> STOP when `run`=0.
  - Any state -> ACK on a load handshake.
  - ACK -> RUN if `run`=1, else STOP, after exactly one cycle.
- `load_ready` = 0 only in ACK.
- Counting: a `tick` is acted on only in state RUN. `tick` in STOP or ACK is dropped, with no buffering.
- Increment datapath:
  - Each field feeds a 6-bit ripple adder with b = 1.
  - `hour` is zero-extended to 6 bits; its sum is truncated to 5 bits.
  - The adder carry-out is unused, since it can never assert for legal values.
- Wrap rules:
  - If `sec` = N_SEC-1, `sec` goes to 0 and `min` increments.
  - If `min` also = N_MIN-1, `min` goes to 0 and `hour` increments.
  - If `hour` also = N_HOUR-1, `hour` goes to 0.
  - All affected fields update on the same edge.
- Load handshake:
  - Fires when `load_valid` and `load_ready` are both 1.
  - If all three fields are in range, they are written on that edge.
  - Otherwise fields are unchanged and `load_err` pulses on the next cycle.
  - The FSM enters ACK in both cases.
- Simultaneous load handshake and `tick`: load wins and the tick is dropped.
- `run` toggling while `tick`=1: the state sampled at the edge decides. STOP at the edge means no count.
- Reset mid-operation overrides load and tick. A pending `load_valid` is ignored during reset and can handshake on the first cycle after reset.

## Timing
- Latency from `tick` to a field update: 1 cycle. The new value is visible after the edge that samples `tick`.
- `min_pulse` and `day_pulse` are registered and coincide with the edge on which `sec` shows 0.
- Latency from a load handshake to the new fields: 1 cycle.
- `load_err` asserts 1 cycle after the handshake and lasts 1 cycle.
- Back-to-back loads: at most one accepted every 2 cycles, because of ACK.
- Maximum count rate: one increment per cycle if `tick` is held high. The ripple carry path of 6 full adders sets the critical path.

## Structure
- Shared package `clock_pkg` holds:
  - widths `SEC_W`=6, `MIN_W`=6, `HOUR_W`=5;
  - moduli `N_SEC`, `N_MIN`, `N_HOUR`;
  - FSM state encoding (STOP, RUN, ACK).
- Sub-module `mod_field`, one instance per field:
  - parameters: width, modulus;
  - inputs: `inc`, `load`, `load_val`;
  - outputs: `val`, `wrap` (combinational, asserted when `val` = modulus-1 and `inc` = 1);
  - wraps a `ripplenbit_add` (N=6) as its incrementer.
- Top level holds the FSM, range check, wrap chaining and pulse registers.

## Test plan
- Reset with `run`=1 and `tick` held -> on the first cycle after reset, time = 00:00:00, `load_ready`=1, and no count occurred during reset.
- Load 00:00:59 then `tick` in RUN -> next cycle reads 00:01:00 with `min_pulse`=1 for exactly one cycle.
- Load 23:59:59, `run`=1, `tick` -> 00:00:00, with `day_pulse` and `min_pulse` both 1 for one cycle.
- Load with `sec`=60 -> fields unchanged, `load_err`=1 one cycle later, `load_ready`=0 for one cycle.
- `load_valid` and `tick` on the same cycle (load 10:20:30) -> 10:20:30 with no increment; a `tick` 2 cycles later gives 10:20:31.
- `run`=0 with 5 ticks -> time holds. Then `run`=1 and 5 ticks -> +5 s. Then assert `rst` mid-run -> 00:00:00 and state STOP.

Source files
------------

// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the hours/minutes/seconds timekeeping datapath.
//   - field widths for seconds, minutes and hours
//   - width of the ripple incrementer every field shares
//   - default moduli for each field
//   - run/stop/acknowledge FSM state encoding
//   - range-check helper used on preset values
// ---------------------------------------------------------------------------
package clock_pkg;

  // Field widths.
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  // Every field increments through the same 6-bit ripple adder;
  // the narrower hours field is zero-extended into it.
  localparam int ADD_W  = 6;

  // Default moduli (one past the largest legal field value).
  localparam int N_SEC  = 60;
  localparam int N_MIN  = 60;
  localparam int N_HOUR = 24;

  // Run/stop FSM.  ACK is the single cycle that follows any load handshake.
  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    ACK  = 2'd2
  } state_t;

  // True when a preset value lies inside 0..modulus-1.
  // The value arrives zero-extended to the adder width so one helper
  // serves all three fields.
  function automatic logic in_range(input logic [ADD_W-1:0] value,
                                    input int               modulus);
    logic [31:0] wide;
    wide = {26'd0, value};
    return (wide < 32'(modulus));
  endfunction

endpackage : clock_pkg

// File: rtl/mod_field.sv
// ---------------------------------------------------------------------------
// mod_field
// One modulo-MOD time field (seconds, minutes or hours).
//   - holds its value in a register
//   - advances by one on inc, using a shared-width ripple incrementer
//   - wraps MOD-1 -> 0 and flags the wrap combinationally
//   - a load overrides any increment on the same edge
// Ports:
//   clk       in  1  rising-edge clock
//   rst       in  1  synchronous active-high reset, clears val
//   inc       in  1  advance the field by one this edge
//   load      in  1  write load_val this edge (has priority over inc)
//   load_val  in  W  value to write on load
//   val       out W  current field value (registered)
//   wrap      out 1  inc is set while val = MOD-1 (combinational)
// ---------------------------------------------------------------------------
module mod_field #(
  parameter int W   = 6,
  parameter int MOD = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] val,
  output logic         wrap
);

  import clock_pkg::*;

  // Largest legal value; reaching it means the next increment wraps.
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [ADD_W-1:0] add_a;
  logic [ADD_W-1:0] add_sum;
  logic             add_cout;
  logic [W-1:0]     next_val;

  // Narrow fields are zero-extended into the adder.
  assign add_a = ADD_W'(val);

  ripplenbit_add #(
    .N (ADD_W)
  ) u_inc (
    .a    (add_a),
    .b    (6'd1),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The carry-out cannot assert for any legal field value,
  // so the incremented value is just the truncated sum.
  assign next_val = add_sum[W-1:0];

  assign wrap = inc && (val == LAST);

  // Field register: reset, then load, then increment-or-wrap, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      val <= '0;
    end else if (load) begin
      val <= load_val;
    end else if (inc) begin
      if (val == LAST) begin
        val <= '0;
      end else begin
        val <= next_val;
      end
    end else begin
      val <= val;
    end
  end

endmodule : mod_field

// File: rtl/ripplenbit_add.sv
// ---------------------------------------------------------------------------
// ripplenbit_add
// N-bit ripple-carry adder built from a chain of full adders.
// Ports:
//   a, b  in  N  addends
//   cin   in  1  carry into bit 0
//   sum   out N  a + b + cin, modulo 2**N
//   cout  out 1  carry out of the top bit
// ---------------------------------------------------------------------------
module ripplenbit_add #(
  parameter int N = 6
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // carry[i] is the carry entering bit i; carry[N] leaves the adder.
  logic [N:0] carry;

  assign carry[0] = cin;

  // One full adder per bit; the carry ripples from bit 0 upward.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  assign cout = carry[N];

endmodule : ripplenbit_add

// File: rtl/hms_time_counter.sv
// ---------------------------------------------------------------------------
// hms_time_counter
// Hours/minutes/seconds timekeeping counter.
//   - three mod_field instances (sec, min, hour) chained by their wrap flags
//   - STOP/RUN/ACK FSM; ticks are only counted in RUN
//   - valid/ready preset port with range check; ACK throttles loads to
//     one every two cycles and load_err reports a rejected preset
//   - registered min_pulse / day_pulse mark seconds and day rollovers
// Ports:
//   clk         in  1  rising-edge clock
//   rst         in  1  synchronous active-high reset
//   tick        in  1  one-cycle count enable
//   run         in  1  level: 1 = count, 0 = hold
//   load_valid  in  1  preset request
//   load_ready  out 1  preset can be accepted this cycle (0 only in ACK)
//   load_sec    in  6  preset seconds
//   load_min    in  6  preset minutes
//   load_hour   in  5  preset hours
//   load_err    out 1  one-cycle pulse after a rejected preset
//   sec         out 6  current seconds
//   min         out 6  current minutes
//   hour        out 5  current hours
//   min_pulse   out 1  one-cycle pulse on a seconds wrap
//   day_pulse   out 1  one-cycle pulse on the 23:59:59 -> 00:00:00 wrap
// ---------------------------------------------------------------------------
module hms_time_counter #(
  parameter int N_SEC  = clock_pkg::N_SEC,
  parameter int N_MIN  = clock_pkg::N_MIN,
  parameter int N_HOUR = clock_pkg::N_HOUR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         run,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [clock_pkg::SEC_W-1:0]  load_sec,
  input  logic [clock_pkg::MIN_W-1:0]  load_min,
  input  logic [clock_pkg::HOUR_W-1:0] load_hour,
  output logic                         load_err,
  output logic [clock_pkg::SEC_W-1:0]  sec,
  output logic [clock_pkg::MIN_W-1:0]  min,
  output logic [clock_pkg::HOUR_W-1:0] hour,
  output logic                         min_pulse,
  output logic                         day_pulse
);

  import clock_pkg::*;

  state_t state;

  logic handshake;
  logic range_ok;
  logic load_ok;
  logic count_en;
  logic sec_wrap;
  logic min_wrap;
  logic hour_wrap;

  assign handshake = load_valid && load_ready;

  assign range_ok = in_range(ADD_W'(load_sec),  N_SEC)  &&
                    in_range(ADD_W'(load_min),  N_MIN)  &&
                    in_range(ADD_W'(load_hour), N_HOUR);

  assign load_ok = handshake && range_ok;

  // A tick counts only in RUN, and a simultaneous handshake takes the edge.
  assign count_en = (state == RUN) && tick && !handshake;

  // Seconds advance on a counted tick; minutes and hours advance on the
  // wrap of the field below, so a full rollover lands on one edge.
  mod_field #(
    .W   (SEC_W),
    .MOD (N_SEC)
  ) u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (count_en),
    .load     (load_ok),
    .load_val (load_sec),
    .val      (sec),
    .wrap     (sec_wrap)
  );

  mod_field #(
    .W   (MIN_W),
    .MOD (N_MIN)
  ) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (sec_wrap),
    .load     (load_ok),
    .load_val (load_min),
    .val      (min),
    .wrap     (min_wrap)
  );

  mod_field #(
    .W   (HOUR_W),
    .MOD (N_HOUR)
  ) u_hour (
    .clk      (clk),
    .rst      (rst),
    .inc      (min_wrap),
    .load     (load_ok),
    .load_val (load_hour),
    .val      (hour),
    .wrap     (hour_wrap)
  );

  // Run/stop/acknowledge FSM with registered load_ready and load_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STOP;
      load_ready <= 1'b1;
      load_err   <= 1'b0;
    end else begin
      load_err <= handshake && !range_ok;
      if (handshake) begin
        state      <= ACK;
        load_ready <= 1'b0;
      end else begin
        load_ready <= 1'b1;
        case (state)
          STOP: begin
            if (run) begin
              state <= RUN;
            end else begin
              state <= STOP;
            end
          end
          RUN: begin
            if (run) begin
              state <= RUN;
            end else begin
              state <= STOP;
            end
          end
          ACK: begin
            if (run) begin
              state <= RUN;
            end else begin
              state <= STOP;
            end
          end
          default: begin
            state <= STOP;
          end
        endcase
      end
    end
  end

  // Rollover pulses, registered so they line up with sec reading 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_pulse <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      min_pulse <= sec_wrap;
      day_pulse <= hour_wrap;
    end
  end

endmodule : hms_time_counter

// File: tb/tb_hms_time_counter.sv
// ---------------------------------------------------------------------------
// tb_hms_time_counter
// Directed self-checking bench for hms_time_counter.  Inputs change and
// outputs are sampled 1 ns after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_hms_time_counter;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       run;
  logic       load_valid;
  logic       load_ready;
  logic [5:0] load_sec;
  logic [5:0] load_min;
  logic [4:0] load_hour;
  logic       load_err;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       min_pulse;
  logic       day_pulse;

  int total;
  int bad;

  hms_time_counter dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .run        (run),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_sec   (load_sec),
    .load_min   (load_min),
    .load_hour  (load_hour),
    .load_err   (load_err),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .min_pulse  (min_pulse),
    .day_pulse  (day_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".hour"}, 32'(hour), 32'(h));
    chk({tag, ".min"},  32'(min),  32'(m));
    chk({tag, ".sec"},  32'(sec),  32'(s));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a preset for exactly one edge (inputs already settled).
  task automatic do_load(input int h, input int m, input int s);
    load_hour  = 5'(h);
    load_min   = 6'(m);
    load_sec   = 6'(s);
    load_valid = 1'b1;
    cyc();
    load_valid = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    run        = 1'b1;
    tick       = 1'b1;
    load_valid = 1'b0;
    load_sec   = 6'd0;
    load_min   = 6'd0;
    load_hour  = 5'd0;

    // Reset with run and tick held: nothing may count.
    #1;
    repeat (3) cyc();
    rst  = 1'b0;
    tick = 1'b0;
    run  = 1'b0;
    chk_time("reset", 0, 0, 0);
    chk("reset.ready", 32'(load_ready), 32'd1);
    chk("reset.err",   32'(load_err),   32'd0);
    chk("reset.minp",  32'(min_pulse),  32'd0);
    chk("reset.dayp",  32'(day_pulse),  32'd0);

    // Load 00:00:59 then tick in RUN -> 00:01:00 with one min_pulse.
    run = 1'b1;
    do_load(0, 0, 59);
    chk_time("ld59", 0, 0, 59);
    chk("ld59.ready_ack", 32'(load_ready), 32'd0);
    chk("ld59.err",       32'(load_err),   32'd0);
    cyc();
    chk("ld59.ready_back", 32'(load_ready), 32'd1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk_time("wrap_s", 0, 1, 0);
    chk("wrap_s.minp", 32'(min_pulse), 32'd1);
    chk("wrap_s.dayp", 32'(day_pulse), 32'd0);
    cyc();
    chk("wrap_s.minp_end", 32'(min_pulse), 32'd0);
    chk_time("wrap_s.hold", 0, 1, 0);

    // Minutes carry into hours: 00:59:59 -> 01:00:00.
    do_load(0, 59, 59);
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk_time("wrap_m", 1, 0, 0);
    chk("wrap_m.dayp", 32'(day_pulse), 32'd0);

    // Day rollover: 23:59:59 -> 00:00:00 with both pulses.
    do_load(23, 59, 59);
    chk_time("ld_day", 23, 59, 59);
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk_time("wrap_d", 0, 0, 0);
    chk("wrap_d.minp", 32'(min_pulse), 32'd1);
    chk("wrap_d.dayp", 32'(day_pulse), 32'd1);
    cyc();
    chk("wrap_d.minp_end", 32'(min_pulse), 32'd0);
    chk("wrap_d.dayp_end", 32'(day_pulse), 32'd0);

    // Out-of-range presets are rejected with a one-cycle load_err.
    do_load(5, 5, 60);
    chk_time("bad_sec", 0, 0, 0);
    chk("bad_sec.err",   32'(load_err),   32'd1);
    chk("bad_sec.ready", 32'(load_ready), 32'd0);
    cyc();
    chk("bad_sec.err_end",  32'(load_err),   32'd0);
    chk("bad_sec.ready_bk", 32'(load_ready), 32'd1);
    do_load(3, 60, 3);
    chk_time("bad_min", 0, 0, 0);
    chk("bad_min.err", 32'(load_err), 32'd1);
    cyc();
    do_load(24, 0, 0);
    chk_time("bad_hour", 0, 0, 0);
    chk("bad_hour.err", 32'(load_err), 32'd1);
    cyc();

    // Load and tick together: load wins; tick during ACK is dropped;
    // the tick two cycles after the load counts.
    tick = 1'b1;
    do_load(10, 20, 30);
    chk_time("ld_tick", 10, 20, 30);
    cyc();
    chk_time("ack_tick", 10, 20, 30);
    cyc();
    tick = 1'b0;
    chk_time("tick_after", 10, 20, 31);

    // Stopped: five ticks hold; running: five ticks add five seconds.
    run = 1'b0;
    cyc();
    tick = 1'b1;
    repeat (5) cyc();
    tick = 1'b0;
    chk_time("stop5", 10, 20, 31);
    run = 1'b1;
    cyc();
    tick = 1'b1;
    repeat (5) cyc();
    chk_time("run5", 10, 20, 36);

    // Reset mid-run with a load pending: clears time, state back to STOP.
    rst        = 1'b1;
    load_valid = 1'b1;
    load_hour  = 5'd7;
    load_min   = 6'd7;
    load_sec   = 6'd7;
    cyc();
    rst        = 1'b0;
    load_valid = 1'b0;
    chk_time("rst_mid", 0, 0, 0);
    chk("rst_mid.ready", 32'(load_ready), 32'd1);
    cyc();
    chk_time("rst_stop", 0, 0, 0);
    cyc();
    tick = 1'b0;
    chk_time("rst_run", 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hms_time_counter
